// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant controller.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N_DEF    = 4;
  localparam int ARB_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first bit of vec set and not excluded,
// scanning upward from start and wrapping modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N    = ARB_N_DEF,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] start,
  input  logic [N-1:0]    excl,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] pos_s;
  logic            hit_s;

  // Scan positions start, start+1, ... and latch the first eligible one.
  always_comb begin
    found = 1'b0;
    idx   = {IDXW{1'b0}};
    pos_s = {IDXW{1'b0}};
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos_s = IDXW'((int'(start) + i) % N);
      hit_s = vec[pos_s] & ~excl[pos_s] & ~found;
      found = found | hit_s;
      idx   = hit_s ? pos_s : idx;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin single-owner grant controller with tenure-limited preemption.
// Define RR_GRANT_PROPS_EN to elaborate the embedded properties and covers.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N_DEF,
  parameter  int HOLD_MAX = ARB_HOLD_DEF,
  localparam int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_id,
  output logic            busy,
  output logic            preempt
);

  localparam int              TENW     = $clog2(HOLD_MAX + 1);
  localparam logic [TENW-1:0] TEN_LAST = TENW'(HOLD_MAX - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    GNT_ONE  = N'(1'b1);

  arb_state_e      state_q,   state_d;
  logic [N-1:0]    gnt_q,     gnt_d;
  logic [IDXW-1:0] gnt_id_q,  gnt_id_d;
  logic [IDXW-1:0] ptr_q,     ptr_d;
  logic [TENW-1:0] tenure_q,  tenure_d;
  logic            busy_q,    busy_d;
  logic            preempt_q, preempt_d;

  logic [N-1:0]    excl_s;
  logic            pick_found_s;
  logic [IDXW-1:0] pick_idx_s;

  // While busy ptr_q is already owner+1, so one search serves both the idle
  // pick and the preemption pick; only the owner must be masked out.
  always_comb begin
    if (state_q == ARB_BUSY) begin
      excl_s = gnt_q;
    end else begin
      excl_s = {N{1'b0}};
    end
  end

  rr_pick #(.N(N)) u_pick (
    .vec   (req),
    .start (ptr_q),
    .excl  (excl_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    preempt_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d  = ARB_BUSY;
          gnt_d    = GNT_ONE << pick_idx_s;
          gnt_id_d = pick_idx_s;
          ptr_d    = (pick_idx_s == IDX_LAST) ? {IDXW{1'b0}} : pick_idx_s + IDXW'(1'b1);
          tenure_d = {TENW{1'b0}};
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // Release outranks preemption and always costs a bubble cycle.
        if (!req[gnt_id_q]) begin
          state_d  = ARB_IDLE;
          gnt_d    = {N{1'b0}};
          tenure_d = {TENW{1'b0}};
        end else if ((tenure_q == TEN_LAST) && pick_found_s) begin
          gnt_d     = GNT_ONE << pick_idx_s;
          gnt_id_d  = pick_idx_s;
          ptr_d     = (pick_idx_s == IDX_LAST) ? {IDXW{1'b0}} : pick_idx_s + IDXW'(1'b1);
          tenure_d  = {TENW{1'b0}};
          preempt_d = 1'b1;
        end else if (tenure_q != TEN_LAST) begin
          tenure_d = tenure_q + TENW'(1'b1);
        end else begin
          tenure_d = tenure_q;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        gnt_d    = {N{1'b0}};
        tenure_d = {TENW{1'b0}};
      end
    endcase
    busy_d = |gnt_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= {N{1'b0}};
      gnt_id_q  <= {IDXW{1'b0}};
      ptr_q     <= {IDXW{1'b0}};
      tenure_q  <= {TENW{1'b0}};
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

`ifdef RR_GRANT_PROPS_EN
  default clocking cb_props @(posedge clk); endclocking
  default disable iff (!rstn);

  a_onehot:  assert property ($onehot0(gnt));
  a_busy:    assert property (32'(busy) == $countones(gnt));
  a_new_gnt: assert property (((gnt != {N{1'b0}}) && (gnt != $past(gnt)))
                              |-> ((gnt & ~$past(req)) == {N{1'b0}}));
  a_preempt: assert property (preempt |-> $past(busy));
  // Held-and-contended for HOLD_MAX consecutive stable cycles means the
  // tenure ran past its limit.
  a_hold:    assert property (not (($stable(gnt) && busy
                                   && ((req & ~gnt) != {N{1'b0}})) [*HOLD_MAX]));

  c_preempt: cover property (preempt);
  c_wrap:    cover property (gnt[N-1] ##[1:2] gnt[0]);
`else
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed scoreboard bench for rr_grant_ctrl with N=4, HOLD_MAX=4.
module tb_rr_grant_ctrl;

  localparam int N    = 4;
  localparam int H    = 4;
  localparam int IDXW = 2;

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] id;
    logic            busy;
    logic            pre;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_id;
  logic            busy;
  logic            preempt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.N(N), .HOLD_MAX(H)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  task automatic push(input logic [N-1:0] g, input logic [IDXW-1:0] id, input logic pre);
    exp_t e;
    e.gnt  = g;
    e.id   = id;
    e.busy = |g;
    e.pre  = pre;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      assert (gnt === e.gnt) else begin
        fails++;
        $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e.gnt);
      end
      tests++;
      assert (gnt_id === e.id) else begin
        fails++;
        $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, e.id);
      end
      tests++;
      assert (busy === e.busy) else begin
        fails++;
        $error("FAIL %s busy observed=%b expected=%b", tag, busy, e.busy);
      end
      tests++;
      assert (preempt === e.pre) else begin
        fails++;
        $error("FAIL %s preempt observed=%b expected=%b", tag, preempt, e.pre);
      end
    end
  endtask

  // Drive req for one edge, record what that edge must produce, then check.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] g,
                      input logic [IDXW-1:0] id, input logic pre, input string tag);
    @(negedge clk);
    req = r;
    push(g, id, pre);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rstn = 1'b0;
    req  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    push(4'b0000, 2'd0, 1'b0);
    check("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Basic grant, release bubble, then pointer wrap.
    step(4'b1010, 4'b0010, 2'd1, 1'b0, "first_gnt");
    step(4'b1000, 4'b0000, 2'd1, 1'b0, "release_bubble");
    step(4'b1000, 4'b1000, 2'd3, 1'b0, "after_bubble");
    step(4'b0000, 4'b0000, 2'd3, 1'b0, "release_3");

    // Preemption ping-pong between 0 and 1; ptr must now be 0.
    for (int i = 0; i < H; i++) step(4'b0011, 4'b0001, 2'd0, 1'b0, "owner0");
    step(4'b0011, 4'b0010, 2'd1, 1'b1, "preempt_to1");
    for (int i = 1; i < H; i++) step(4'b0011, 4'b0010, 2'd1, 1'b0, "owner1");
    step(4'b0011, 4'b0001, 2'd0, 1'b1, "preempt_to0");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "release_0");

    // Lone owner keeps the grant with no preemption.
    for (int i = 0; i < 20; i++) step(4'b0100, 4'b0100, 2'd2, 1'b0, "lone_owner");
    step(4'b0000, 4'b0000, 2'd2, 1'b0, "release_2");

    // Release on the preemption cycle: bubble wins, no preempt pulse.
    step(4'b0001, 4'b0001, 2'd0, 1'b0, "tie_gnt0");
    for (int i = 1; i < H; i++) step(4'b1001, 4'b0001, 2'd0, 1'b0, "tie_hold");
    step(4'b1000, 4'b0000, 2'd0, 1'b0, "tie_release");
    step(4'b1000, 4'b1000, 2'd3, 1'b0, "tie_next");
    step(4'b1000, 4'b1000, 2'd3, 1'b0, "tie_keep");

    // Asynchronous reset mid-grant.
    @(negedge clk);
    #2;
    rstn = 1'b0;
    req  = 4'b0000;
    #1;
    push(4'b0000, 2'd0, 1'b0);
    check("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b0, "post_reset_gnt");
    for (int i = 1; i < H; i++) step(4'b1111, 4'b0001, 2'd0, 1'b0, "post_reset_hold");
    step(4'b1111, 4'b0010, 2'd1, 1'b1, "post_reset_preempt");
    step(4'b0000, 4'b0000, 2'd1, 1'b0, "post_reset_release");

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain leftover=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
